// File: rtl/mem_stream_loader.sv
// mem_stream_loader: parses a framed byte stream (4-byte start byte address,
// 4-byte byte count, payload) and writes the payload into a byte-write-enabled
// 32-bit synchronous RAM. Each word touched produces exactly one single-cycle
// write carrying only the lanes that were filled.
module mem_stream_loader #(
    parameter int AWIDTH = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [31:0]       mem_d,
    output logic [3:0]        mem_wbe,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        HDR_ADDR,
        HDR_LEN,
        DATA,
        DONE
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [1:0]  hdr_cnt;
    logic [31:0] byte_addr;
    logic [31:0] remaining;
    logic [31:0] word_buf;
    logic [3:0]  lane_mask;

    logic        accept;
    logic [1:0]  lane;
    logic        last_hdr_byte;
    logic [31:0] next_len;
    logic        flush;
    logic [31:0] merged_buf;
    logic [3:0]  merged_mask;
    logic [31:0] lane_bits;

    logic        in_ready_d;
    logic        busy_d;
    logic        done_d;

    // Transfer qualification and the word being assembled once this byte lands
    always_comb begin
        accept        = in_valid && in_ready;
        lane          = byte_addr[1:0];
        last_hdr_byte = accept && (hdr_cnt == 2'd3);
        next_len      = {in_data, remaining[31:8]};
        merged_buf    = word_buf;
        merged_buf[{lane, 3'b000} +: 8] = in_data;
        merged_mask   = lane_mask | (4'b0001 << lane);
        lane_bits     = {{8{merged_mask[3]}}, {8{merged_mask[2]}},
                         {8{merged_mask[1]}}, {8{merged_mask[0]}}};
        flush         = accept && (state == DATA) &&
                        ((lane == 2'd3) || (remaining == 32'd1));
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; start only matters while idle or finished
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start) next_state = HDR_ADDR;
            HDR_ADDR: if (last_hdr_byte) next_state = HDR_LEN;
            HDR_LEN:  if (last_hdr_byte) next_state = (next_len != 32'd0) ? DATA : DONE;
            DATA:     if (accept && (remaining == 32'd1)) next_state = DONE;
            DONE:     if (start) next_state = HDR_ADDR;
            default:  next_state = IDLE;
        endcase
    end

    // Status outputs are decoded from the upcoming state so they can be registered
    always_comb begin
        in_ready_d = (next_state == HDR_ADDR) || (next_state == HDR_LEN) ||
                     (next_state == DATA);
        busy_d     = in_ready_d;
        done_d     = (next_state == DONE);
    end

    // Registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            in_ready <= in_ready_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    // Header capture, payload packing and RAM write issue
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hdr_cnt   <= 2'd0;
            byte_addr <= 32'd0;
            remaining <= 32'd0;
            word_buf  <= 32'd0;
            lane_mask <= 4'd0;
            mem_addr  <= '0;
            mem_d     <= 32'd0;
            mem_wbe   <= 4'd0;
        end else begin
            mem_wbe <= 4'd0;
            if ((state == IDLE || state == DONE) && start) begin
                hdr_cnt <= 2'd0;
            end
            if (accept) begin
                case (state)
                    HDR_ADDR: begin
                        byte_addr <= {in_data, byte_addr[31:8]};
                        hdr_cnt   <= hdr_cnt + 2'd1;
                    end
                    HDR_LEN: begin
                        remaining <= next_len;
                        hdr_cnt   <= hdr_cnt + 2'd1;
                    end
                    DATA: begin
                        byte_addr <= byte_addr + 32'd1;
                        remaining <= remaining - 32'd1;
                        if (flush) begin
                            mem_addr  <= byte_addr[AWIDTH+1:2];
                            mem_d     <= merged_buf & lane_bits;
                            mem_wbe   <= merged_mask;
                            word_buf  <= 32'd0;
                            lane_mask <= 4'd0;
                        end else begin
                            word_buf  <= merged_buf;
                            lane_mask <= merged_mask;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_stream_loader.sv
// Testbench for mem_stream_loader: directed and randomised frames compared
// against a word-grouping reference model of the expected RAM writes.
module tb_mem_stream_loader;

    localparam int AWIDTH = 14;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        in_data = 8'd0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [AWIDTH-1:0] mem_addr;
    logic [31:0]       mem_d;
    logic [3:0]        mem_wbe;
    logic              busy;
    logic              done;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]        payload[$];
    logic [AWIDTH-1:0] exp_addr[$];
    logic [31:0]       exp_d[$];
    logic [3:0]        exp_wbe[$];
    logic [AWIDTH-1:0] cap_addr[$];
    logic [31:0]       cap_d[$];
    logic [3:0]        cap_wbe[$];

    mem_stream_loader #(.AWIDTH(AWIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_addr (mem_addr),
        .mem_d    (mem_d),
        .mem_wbe  (mem_wbe),
        .busy     (busy),
        .done     (done)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Record every RAM write cycle seen by the memory
    always @(negedge clk) begin
        if (rst && mem_wbe != 4'd0) begin
            cap_addr.push_back(mem_addr);
            cap_d.push_back(mem_d);
            cap_wbe.push_back(mem_wbe);
        end
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: payload byte i lands at byte address A+i; bytes sharing a
    // word index form one write to that word, in stream order
    task automatic build_expected(input logic [31:0] a0, input int n);
        logic [31:0] a;
        logic [29:0] cur;
        logic [31:0] d;
        logic [3:0]  m;
        int          lane;
        exp_addr.delete();
        exp_d.delete();
        exp_wbe.delete();
        cur = '0;
        d   = '0;
        m   = '0;
        for (int i = 0; i < n; i++) begin
            a = a0 + 32'(i);
            if (i > 0 && a[31:2] != cur) begin
                exp_addr.push_back(cur[AWIDTH-1:0]);
                exp_d.push_back(d);
                exp_wbe.push_back(m);
            end
            if (i == 0 || a[31:2] != cur) begin
                cur = a[31:2];
                d   = '0;
                m   = '0;
            end
            lane = int'(a[1:0]);
            d[lane*8 +: 8] = payload[i];
            m[lane] = 1'b1;
        end
        if (n > 0) begin
            exp_addr.push_back(cur[AWIDTH-1:0]);
            exp_d.push_back(d);
            exp_wbe.push_back(m);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_output("armed_busy", busy, 1);
        check_output("armed_done", done, 0);
        check_output("armed_ready", in_ready, 1);
    endtask

    // Present one byte after some idle bubbles; called and returns on a negedge
    task automatic apply_stimulus(input logic [7:0] b, input int bubbles, input logic noisy);
        int guard;
        repeat (bubbles) @(negedge clk);
        guard = 0;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check_output("ready_timeout", in_ready, 1);
        in_valid = 1'b1;
        in_data  = b;
        start    = noisy;
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic run_frame(input string name, input logic [31:0] a0, input int n,
                             input int max_bubble, input logic noisy);
        logic [31:0] nl;
        int m;
        nl = 32'(n);
        cap_addr.delete();
        cap_d.delete();
        cap_wbe.delete();
        build_expected(a0, n);
        pulse_start();
        for (int i = 0; i < 4; i++) apply_stimulus(a0[i*8 +: 8], $urandom_range(0, max_bubble), 1'b0);
        for (int i = 0; i < 4; i++) apply_stimulus(nl[i*8 +: 8], $urandom_range(0, max_bubble), noisy);
        for (int i = 0; i < n; i++) apply_stimulus(payload[i], $urandom_range(0, max_bubble), noisy);
        check_output({name, "_done"}, done, 1);
        check_output({name, "_busy"}, busy, 0);
        check_output({name, "_ready"}, in_ready, 0);
        if (n > 0) begin
            check_output({name, "_lastwbe"}, mem_wbe, exp_wbe[exp_wbe.size()-1]);
            check_output({name, "_lastaddr"}, mem_addr, exp_addr[exp_addr.size()-1]);
            check_output({name, "_lastd"}, mem_d, exp_d[exp_d.size()-1]);
        end else begin
            check_output({name, "_nowbe"}, mem_wbe, 0);
        end
        repeat (2) @(negedge clk);
        check_output({name, "_wbe_idle"}, mem_wbe, 0);
        check_output({name, "_done_hold"}, done, 1);
        check_output({name, "_nwrites"}, cap_wbe.size(), exp_wbe.size());
        m = (cap_wbe.size() < exp_wbe.size()) ? cap_wbe.size() : exp_wbe.size();
        for (int i = 0; i < m; i++) begin
            check_output({name, "_addr"}, cap_addr[i], exp_addr[i]);
            check_output({name, "_d"}, cap_d[i], exp_d[i]);
            check_output({name, "_wbe"}, cap_wbe[i], exp_wbe[i]);
        end
    endtask

    task automatic load_test1();
        payload.delete();
        for (int i = 0; i < 8; i++) payload.push_back(8'h11 + 8'(i));
    endtask

    initial begin
        int n;
        // Reset state
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_output("rst_ready", in_ready, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_done", done, 0);
        check_output("rst_wbe", mem_wbe, 0);
        check_output("rst_addr", mem_addr, 0);
        check_output("rst_d", mem_d, 0);
        rst = 1'b1;
        @(negedge clk);
        check_output("idle_ready", in_ready, 0);

        // Aligned two-word frame, with constants from the plan
        load_test1();
        run_frame("t1", 32'h10, 8, 0, 1'b0);
        check_output("t1_const_a0", exp_addr[0], 14'd4);
        check_output("t1_const_d0", cap_d.size() > 0 ? cap_d[0] : 32'hx, 32'h14131211);
        check_output("t1_const_d1", cap_d.size() > 1 ? cap_d[1] : 32'hx, 32'h18171615);

        // Unaligned start spanning two words
        payload = '{8'hAA, 8'hBB, 8'hCC};
        run_frame("t2", 32'h3, 3, 0, 1'b0);
        check_output("t2_const_d0", cap_d.size() > 0 ? cap_d[0] : 32'hx, 32'hAA000000);
        check_output("t2_const_d1", cap_d.size() > 1 ? cap_d[1] : 32'hx, 32'h0000CCBB);

        // Empty frame
        payload.delete();
        run_frame("t3", 32'h40, 0, 0, 1'b0);

        // Same frame as first, random bubbles
        load_test1();
        run_frame("t4", 32'h10, 8, 5, 1'b0);

        // Asynchronous reset in the middle of the payload
        load_test1();
        cap_wbe.delete();
        pulse_start();
        for (int i = 0; i < 4; i++) apply_stimulus(8'(32'h10 >> (8*i)), 0, 1'b0);
        for (int i = 0; i < 4; i++) apply_stimulus(8'(32'h8 >> (8*i)), 0, 1'b0);
        apply_stimulus(8'h11, 0, 1'b0);
        apply_stimulus(8'h12, 0, 1'b0);
        #2 rst = 1'b0;
        #1;
        check_output("mr_ready", in_ready, 0);
        check_output("mr_busy", busy, 0);
        check_output("mr_done", done, 0);
        check_output("mr_wbe", mem_wbe, 0);
        check_output("mr_addr", mem_addr, 0);
        check_output("mr_d", mem_d, 0);
        check_output("mr_nowrite", cap_wbe.size(), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_frame("t5", 32'h10, 8, 0, 1'b0);

        // Start pulses while busy are ignored; start in DONE rearms
        load_test1();
        run_frame("t6", 32'h10, 8, 1, 1'b1);

        // Address wrap at top of 32-bit space
        payload = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_frame("t7", 32'hFFFFFFFE, 4, 0, 1'b0);
        check_output("t7_const_a0", cap_addr.size() > 0 ? cap_addr[0] : 14'hx, 14'h3FFF);
        check_output("t7_const_d0", cap_d.size() > 0 ? cap_d[0] : 32'hx, 32'h02010000);

        // Random frames
        for (int f = 0; f < 6; f++) begin
            payload.delete();
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
            run_frame("rnd", $urandom, n, 3, f[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
